// File: rtl/program_loader.sv
// program_loader: framed byte-stream writer for instruction memory.
// Holds the core in reset until an image loads with a matching checksum.
module program_loader #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADR,
    output logic [WIDTH-1:0]  MEM_WDATA,
    output logic              CORE_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        ERR_CODE
);
    localparam int IW    = ADDR_W - 2;
    localparam int DEPTH = 2 ** IW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [15:0]       r_len;
    logic [IW-1:0]     r_widx;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [7:0]        r_csum;
    logic [TW-1:0]     r_tmo;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_core;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_err;

    logic        w_ready;
    logic        w_acc;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic        w_last;
    logic        w_tmo;

    assign w_ready   = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    assign w_acc     = BYTE_VALID & w_ready;
    assign w_len     = {BYTE_IN, r_len[7:0]};
    assign w_len_bad = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH));
    assign w_last    = (32'(r_widx) == 32'(r_len) - 32'd1);
    assign w_tmo     = (r_tmo == TW'(TIMEOUT - 1));

    assign BYTE_READY = w_ready;
    assign MEM_WE     = r_we;
    assign MEM_ADR    = r_adr;
    assign MEM_WDATA  = r_wdata;
    assign CORE_RST   = r_core;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR_CODE   = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_widx  <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_csum  <= '0;
            r_tmo   <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_core  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_we <= 1'b0;
            // Idle gap watchdog shared by every byte-consuming state.
            if (w_ready) begin
                if (w_acc) begin
                    r_tmo  <= '0;
                    r_csum <= r_csum ^ BYTE_IN;
                end else if (w_tmo) begin
                    r_state <= S_ERR;
                    r_err   <= 2'b11;
                    r_busy  <= 1'b0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end
            if (w_acc) begin
                case (r_state)
                    S_LEN0: begin
                        r_len[7:0] <= BYTE_IN;
                        r_state    <= S_LEN1;
                    end
                    S_LEN1: begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_state <= S_ERR;
                            r_err   <= 2'b01;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_lane <= r_lane + 2'd1;
                        unique case (r_lane)
                            2'd0: r_word[7:0]   <= BYTE_IN;
                            2'd1: r_word[15:8]  <= BYTE_IN;
                            2'd2: r_word[23:16] <= BYTE_IN;
                            2'd3: begin
                                r_we    <= 1'b1;
                                r_adr   <= {r_widx, 2'b00};
                                r_wdata <= WIDTH'({BYTE_IN, r_word});
                                r_widx  <= r_widx + IW'(1);
                                if (w_last) r_state <= S_CSUM;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        r_busy <= 1'b0;
                        if (BYTE_IN == r_csum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_core  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
            if (START && !w_ready) begin
                r_state <= S_LEN0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 2'b00;
                r_core  <= 1'b0;
                r_csum  <= '0;
                r_widx  <= '0;
                r_lane  <= '0;
                r_tmo   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: vector table, hand sequences and random frames
// checked against a frame-level model of the loader.
module tb_program_loader;
    localparam int AW  = 11;
    localparam int TMO = 16;
    localparam int CAP = (1 << AW) / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          START = 1'b0;
    logic [7:0]    BYTE_IN = 8'h00;
    logic          BYTE_VALID = 1'b0;
    logic          BYTE_READY;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADR;
    logic [31:0]   MEM_WDATA;
    logic          CORE_RST;
    logic          BUSY;
    logic          DONE;
    logic [1:0]    ERR_CODE;

    program_loader #(.WIDTH(32), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .START(START), .BYTE_IN(BYTE_IN),
        .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
        .MEM_WE(MEM_WE), .MEM_ADR(MEM_ADR), .MEM_WDATA(MEM_WDATA),
        .CORE_RST(CORE_RST), .BUSY(BUSY), .DONE(DONE),
        .ERR_CODE(ERR_CODE)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;
    typedef struct {
        string    nm;
        int       n;
        bit       bad;
        int       gap;
        logic [1:0] err;
        int       nwr;
        bit       done;
    } vec_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  nerr = 0;
    int  nchk = 0;

    always @(negedge clk)
        if (MEM_WE) got_q.push_back(wr_t'{MEM_ADR, MEM_WDATA});

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        BYTE_IN = b;
        BYTE_VALID = 1'b1;
        while (!BYTE_READY && k < 40) begin
            tick();
            k++;
        end
        if (!BYTE_READY) chk("ready_wait", 32'(BYTE_READY), 32'd1);
        else tick();
        BYTE_VALID = 1'b0;
    endtask

    // A byte offered on the START cycle must not be consumed.
    task automatic start_pulse();
        START = 1'b1;
        BYTE_VALID = 1'b1;
        BYTE_IN = 8'hFF;
        tick();
        START = 1'b0;
        BYTE_VALID = 1'b0;
    endtask

    task automatic send_bytes(input bq_t fr, input int gap);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (i != fr.size() - 1) repeat (gap) tick();
        end
    endtask

    function automatic bq_t build(input int n, input bit bad);
        bq_t q;
        logic [7:0] x;
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        if (n >= 1 && n <= CAP) begin
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            x = 8'h00;
            foreach (q[i]) x ^= q[i];
            q.push_back(bad ? x ^ 8'h01 : x);
        end
        return q;
    endfunction

    task automatic model(input bq_t fr, output logic [1:0] err);
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = {fr[1], fr[0]};
        if (n == 0 || n > CAP) begin
            err = 2'b01;
            return;
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back(wr_t'{AW'(4 * w),
                {fr[4*w+5], fr[4*w+4], fr[4*w+3], fr[4*w+2]}});
        x = 8'h00;
        for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
        err = (fr[fr.size()-1] == x) ? 2'b00 : 2'b10;
    endtask

    task automatic chk_result(input string nm, input logic [1:0] eerr,
                              input bit edone, input int enwr);
        chk({nm, "_err"}, 32'(ERR_CODE), 32'(eerr));
        chk({nm, "_done"}, 32'(DONE), 32'(edone));
        chk({nm, "_core"}, 32'(CORE_RST), 32'(edone));
        chk({nm, "_busy"}, 32'(BUSY), 32'd0);
        chk({nm, "_nwr"}, 32'(got_q.size()), 32'(enwr));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({nm, "_adr"}, 32'(got_q[i].adr), 32'(exp_q[i].adr));
            chk({nm, "_dat"}, got_q[i].dat, exp_q[i].dat);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ready"}, 32'(BYTE_READY), 32'd0);
        chk({nm, "_we"}, 32'(MEM_WE), 32'd0);
        chk({nm, "_adr"}, 32'(MEM_ADR), 32'd0);
        chk({nm, "_wdata"}, MEM_WDATA, 32'd0);
        chk({nm, "_core"}, 32'(CORE_RST), 32'd0);
        chk({nm, "_busy"}, 32'(BUSY), 32'd0);
        chk({nm, "_done"}, 32'(DONE), 32'd0);
        chk({nm, "_errc"}, 32'(ERR_CODE), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[6];
        bq_t fr;
        logic [1:0] merr;
        logic [AW-1:0] la;
        int n;
        bit bad;
        int gap;

        tv[0] = '{"n1", 1, 1'b0, 0, 2'b00, 1, 1'b1};
        tv[1] = '{"n3bad", 3, 1'b1, 0, 2'b10, 3, 1'b0};
        tv[2] = '{"n0", 0, 1'b0, 0, 2'b01, 0, 1'b0};
        tv[3] = '{"n201", 'h201, 1'b0, 0, 2'b01, 0, 1'b0};
        tv[4] = '{"gap10", 4, 1'b0, 10, 2'b00, 4, 1'b1};
        tv[5] = '{"n200", 'h200, 1'b0, 0, 2'b00, 512, 1'b1};

        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b1;
        tick();

        BYTE_VALID = 1'b1;
        BYTE_IN = 8'hAA;
        repeat (4) begin
            chk("idle_ready", 32'(BYTE_READY), 32'd0);
            tick();
        end
        BYTE_VALID = 1'b0;
        chk("idle_busy", 32'(BUSY), 32'd0);

        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(wr_t'{11'h000, 32'h0000_0013});
        exp_q.push_back(wr_t'{11'h004, 32'h0010_0093});
        start_pulse();
        send_bytes(fr, 0);
        chk_result("good", 2'b00, 1'b1, 2);

        BYTE_VALID = 1'b1;
        BYTE_IN = 8'h55;
        repeat (4) begin
            chk("done_ready", 32'(BYTE_READY), 32'd0);
            tick();
        end
        BYTE_VALID = 1'b0;
        chk("done_hold", 32'(DONE), 32'd1);
        chk("done_nwr", 32'(got_q.size()), 32'd2);

        fr[10] = 8'h99;
        got_q.delete();
        start_pulse();
        send_bytes(fr, 0);
        chk_result("badck", 2'b10, 1'b0, 2);

        foreach (tv[i]) begin
            fr = build(tv[i].n, tv[i].bad);
            model(fr, merr);
            got_q.delete();
            start_pulse();
            send_bytes(fr, tv[i].gap);
            chk_result(tv[i].nm, tv[i].err, tv[i].done, tv[i].nwr);
        end
        la = 'x;
        if (got_q.size() > 0) la = got_q[got_q.size()-1].adr;
        chk("n200_last", 32'(la), 32'h7FC);

        got_q.delete();
        start_pulse();
        send_bytes('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0);
        repeat (TMO - 1) tick();
        chk("tmo_early_err", 32'(ERR_CODE), 32'd0);
        chk("tmo_early_busy", 32'(BUSY), 32'd1);
        tick();
        chk("tmo_err", 32'(ERR_CODE), 32'd3);
        chk("tmo_busy", 32'(BUSY), 32'd0);
        chk("tmo_nwr", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0)
            chk("tmo_dat", got_q[0].dat, 32'h4433_2211);

        got_q.delete();
        start_pulse();
        send_bytes('{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08, 8'h09}, 0);
        chk("mid_busy", 32'(BUSY), 32'd1);
        rst = 1'b0;
        tick();
        chk_reset("midrst");
        rst = 1'b1;
        tick();
        chk("midrst_nwr", 32'(got_q.size()), 32'd2);

        fr = build(2, 1'b0);
        model(fr, merr);
        got_q.delete();
        start_pulse();
        send_bytes(fr, 0);
        chk_result("pre_rs", merr, 1'b1, exp_q.size());
        fr = build(3, 1'b0);
        model(fr, merr);
        got_q.delete();
        start_pulse();
        chk("rs_core", 32'(CORE_RST), 32'd0);
        chk("rs_busy", 32'(BUSY), 32'd1);
        chk("rs_done", 32'(DONE), 32'd0);
        send_bytes(fr, 0);
        chk_result("rs", merr, 1'b1, exp_q.size());

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 9))
                0: n = 0;
                1: n = CAP + 1 + $urandom_range(0, 100);
                default: n = $urandom_range(1, 6);
            endcase
            bad = ($urandom_range(0, 3) == 0);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            fr = build(n, bad);
            model(fr, merr);
            got_q.delete();
            start_pulse();
            send_bytes(fr, gap);
            chk_result("rnd", merr, merr == 2'b00, exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
